// File: rtl/demux_pkg.sv
// Shared constants and types for the 1:4 stream demultiplexer and its lane FIFOs.
package demux_pkg;

  localparam int unsigned NUM_LANES  = 4;
  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_DEPTH  = 4;
  localparam int unsigned DEF_CNT_W  = $clog2(DEF_DEPTH + 1);

  typedef logic [1:0]            lane_sel_t;
  typedef logic [DEF_DATA_W-1:0] data_t;

endpackage

// File: rtl/lane_fifo.sv
// Per-lane first-word-fall-through FIFO; occupancy count resolves full/empty.
module lane_fifo
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap naturally; the count alone decides full/empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head is forced to zero whenever the lane is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/stream_demux4.sv
// Routes one valid/ready stream to four independently back-pressured lane FIFOs.
module stream_demux4
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [DATA_W-1:0]             in_data_i,
  input  lane_sel_t                     in_sel_i,
  output logic [NUM_LANES-1:0]          out_valid_o,
  input  logic [NUM_LANES-1:0]          out_ready_i,
  output logic [NUM_LANES*DATA_W-1:0]   out_data_o,
  output logic [NUM_LANES*CNT_W-1:0]    lane_count_o
);

  logic [NUM_LANES-1:0] lane_full;
  logic [NUM_LANES-1:0] lane_empty;
  logic [NUM_LANES-1:0] lane_push;
  logic                 push_en;

  // Ready depends only on the selected lane; a same-cycle pop never frees a slot.
  assign in_ready_o = ~lane_full[in_sel_i];
  assign push_en    = in_valid_i & in_ready_o;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_push[i] = push_en & (in_sel_i == lane_sel_t'(i));

    lane_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
    ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (lane_push[i]),
      .push_data_i (in_data_i),
      .pop_i       (out_ready_i[i]),
      .head_data_o (out_data_o[DATA_W*i +: DATA_W]),
      .count_o     (lane_count_o[CNT_W*i +: CNT_W]),
      .full_o      (lane_full[i]),
      .empty_o     (lane_empty[i])
    );
  end

  assign out_valid_o = ~lane_empty;

endmodule

// File: tb/tb_stream_demux4.sv
// Scoreboard bench for stream_demux4: directed stimulus, per-lane expected queues.
module tb_stream_demux4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data;
  logic [11:0] lane_count;

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q [4][$];
  int pops [4];

  always #5 clk = ~clk;

  stream_demux4 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .in_sel_i     (in_sel),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .lane_count_o (lane_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ldata(input int i);
    return out_data[4*i +: 4];
  endfunction

  function automatic logic [2:0] lcnt(input int i);
    return lane_count[3*i +: 3];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until accepted; records the expectation at acceptance.
  task automatic send(input logic [1:0] sel, input logic [3:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        exp_q[sel].push_back(data);
        cyc();
        in_valid = 1'b0;
        return;
      end
      cyc();
    end
    chk("send_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    out_ready = 4'b1111;
    while (lane_count != 12'd0 && n < 20) begin
      cyc();
      n++;
    end
    chk("drain_count", 32'(lane_count), 32'(0));
    out_ready = 4'b0000;
  endtask

  // Monitor: every head taken by a consumer must match the oldest expected beat of that lane.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          pops[i]++;
          if (exp_q[i].size() == 0) chk("unexpected_beat", 32'(ldata(i)), 32'hFFFF_FFFF);
          else chk("lane_data", 32'(ldata(i)), 32'(exp_q[i].pop_front()));
        end else if (!out_valid[i]) begin
          chk("idle_data_zero", 32'(ldata(i)), 32'(0));
        end
      end
    end
  end

  initial begin
    int p0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 4'd0;
    out_ready = 4'b0000;
    for (int i = 0; i < 4; i++) pops[i] = 0;

    // Asynchronous reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_lane_count", 32'(lane_count), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // Single beat to lane 2
    send(2'd2, 4'hA);
    @(negedge clk);
    chk("single_valid", 32'(out_valid), 32'(4'b0100));
    chk("single_data", 32'(ldata(2)), 32'(4'hA));
    chk("single_count", 32'(lcnt(2)), 32'(1));
    cyc();
    out_ready = 4'b0100;
    cyc();
    out_ready = 4'b0000;
    @(negedge clk);
    chk("single_drained_valid", 32'(out_valid), 32'(0));
    chk("single_drained_count", 32'(lcnt(2)), 32'(0));
    cyc();

    // Fill lane 1, other lanes stay open
    for (int k = 1; k <= 4; k++) send(2'd1, 4'(k));
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'(0));
    chk("full_count", 32'(lcnt(1)), 32'(4));
    cyc();
    in_sel = 2'd0;
    @(negedge clk);
    chk("other_lane_ready", 32'(in_ready), 32'(1));
    cyc();
    send(2'd0, 4'h7);
    @(negedge clk);
    chk("other_lane_count", 32'(lcnt(0)), 32'(1));
    cyc();
    in_valid = 1'b1;
    in_sel   = 2'd1;
    in_data  = 4'h5;
    @(negedge clk);
    chk("hold_refused", 32'(in_ready), 32'(0));
    cyc();
    out_ready = 4'b0010;
    @(negedge clk);
    chk("full_pop_refused", 32'(in_ready), 32'(0));
    cyc();
    @(negedge clk);
    chk("full_pop_count", 32'(lcnt(1)), 32'(3));
    chk("held_accept_ready", 32'(in_ready), 32'(1));
    exp_q[1].push_back(4'h5);
    cyc();
    in_valid = 1'b0;
    wait_drain();

    // Concurrent push and pop on lane 3 at count 2
    send(2'd3, 4'h8);
    send(2'd3, 4'h9);
    out_ready = 4'b1000;
    in_valid  = 1'b1;
    in_sel    = 2'd3;
    for (int k = 0; k < 4; k++) begin
      in_data = 4'(4'hA + k);
      @(negedge clk);
      chk("pp_ready", 32'(in_ready), 32'(1));
      chk("pp_count", 32'(lcnt(3)), 32'(2));
      exp_q[3].push_back(in_data);
      cyc();
    end
    in_valid = 1'b0;
    wait_drain();

    // Streaming ten beats through lane 0
    p0 = pops[0];
    out_ready = 4'b0001;
    in_sel    = 2'd0;
    in_valid  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = 4'(k);
      @(negedge clk);
      chk("stream_ready", 32'(in_ready), 32'(1));
      chk("stream_valid", 32'(out_valid[0]), 32'(k > 0));
      if (k > 0) chk("stream_latency", 32'(ldata(0)), 32'(k - 1));
      exp_q[0].push_back(in_data);
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last", 32'(ldata(0)), 32'(4'h9));
    cyc();
    @(negedge clk);
    chk("stream_empty", 32'(lcnt(0)), 32'(0));
    chk("stream_pops", 32'(pops[0] - p0), 32'(10));
    cyc();
    out_ready = 4'b0000;

    // Reset with lanes partially filled
    send(2'd0, 4'h1);
    send(2'd0, 4'h2);
    for (int k = 0; k < 3; k++) send(2'd1, 4'(4'h3 + k));
    send(2'd2, 4'h4);
    for (int k = 0; k < 4; k++) send(2'd3, 4'(4'h8 + k));
    @(negedge clk);
    chk("pre_rst_counts", 32'(lane_count), 32'({3'd4, 3'd1, 3'd3, 3'd2}));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_counts", 32'(lane_count), 32'(0));
    chk("mid_rst_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_data", 32'(out_data), 32'(0));
    chk("mid_rst_ready", 32'(in_ready), 32'(1));
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    cyc();
    rst_n = 1'b1;
    cyc();
    p0 = pops[1];
    send(2'd1, 4'hC);
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'(4'b0010));
    chk("post_rst_data", 32'(ldata(1)), 32'(4'hC));
    chk("post_rst_count", 32'(lcnt(1)), 32'(1));
    cyc();
    out_ready = 4'b1111;
    cyc();
    @(negedge clk);
    chk("post_rst_drained", 32'(out_valid), 32'(0));
    chk("post_rst_pops", 32'(pops[1] - p0), 32'(1));
    cyc();
    out_ready = 4'b0000;

    for (int i = 0; i < 4; i++) chk("leftover_expected", 32'(exp_q[i].size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_demux4.md
Name: stream_demux4

Overview:
- Inverse of the team's 4:1 lane mux: routes a single 4-bit input stream to one of four output lanes selected per beat by a 2-bit `sel`.
- Each lane has its own small first-word-fall-through FIFO, so a stalled consumer blocks only its own lane.
- Sits between a single producer and four independent consumers in the FIFO/TLM test fabric.
- All ports use valid/ready handshakes.

Parameters:
- DATA_W, 4, width of each data beat.
- DEPTH, 4, entries per lane FIFO; must be a power of two, at least 2.
- CNT_W, $clog2(DEPTH+1) = 3, width of each lane occupancy count.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer presents a beat.
- in_ready  output  1  beat accepted this cycle when in_valid && in_ready.
- in_data  input  DATA_W  beat payload.
- in_sel  input  2  destination lane (0..3) for this beat.
- out_valid  output  4  bit i: lane i has a beat at its head.
- out_ready  input  4  bit i: consumer i takes the head beat.
- out_data  output  4*DATA_W  lane i head at [DATA_W*i +: DATA_W].
- lane_count  output  4*CNT_W  lane i occupancy at [CNT_W*i +: CNT_W].

Behaviour:
- Reset (rst_n low, asynchronous): all FIFOs flushed immediately, with read/write pointers and counts set to 0.
  - Outputs during and after reset: out_valid = 0, out_data = 0, lane_count = 0, in_ready = 1.
- in_ready = !full[in_sel].
  - It is combinational from in_sel and lane state, and is defined every cycle regardless of in_valid.
  - The producer must hold in_data and in_sel stable while in_valid && !in_ready.
- Push: on in_valid && in_ready, write in_data into lane in_sel and increment its count. Exactly one lane is written per cycle.
- Pop: on out_valid[i] && out_ready[i], lane i advances its read pointer and decrements its count. Pops are independent per lane, so all four lanes may pop in the same cycle.
- Latency: an accepted beat is visible on out_valid/out_data of its lane the cycle after acceptance. There is no same-cycle bypass, including into an empty lane.
- Throughput: one beat per cycle in, and up to one beat per cycle per lane out.
- out_valid[i] = (count[i] != 0). out_data lane i = head entry when valid, else 0, so benches can check it deterministically.
- Simultaneous push and pop on the same lane:
  - count unchanged, both pointers advance, order preserved.
  - When the lane is full, the push is refused (in_ready low) even if the same-cycle pop would free a slot. There is no full-pop-push pass-through.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. full is count == DEPTH and empty is count == 0, so there is no pointer-compare ambiguity.
- Ordering: strict FIFO within a lane. There is no ordering relation between lanes.
- Dropped data: none. A beat is never lost or duplicated, and a refused beat stays on the inputs.
- X on in_sel while in_valid is low has no effect on state. in_ready may then be X; the bench must not sample it.

Decomposition:
- Package demux_pkg:
  - NUM_LANES = 4.
  - typedef lane_sel_t = logic [1:0].
  - typedef data_t = logic [DATA_W-1:0].
  - Default DEPTH constant.
- Sub-module lane_fifo (clk, rst_n, push, push_data, pop, head_data, count, full, empty), instantiated 4 times via generate.
- The top level holds the push-decode and ready-mux logic, and the packing of out_data and lane_count.

Test Plan:
- Reset check: assert rst_n = 0 mid-cycle -> immediately out_valid = 4'b0000, out_data = 0, lane_count = 0, in_ready = 1.
- Single beat: in_sel = 2, in_data = 4'hA accepted.
  - Next cycle out_valid = 4'b0100, lane 2 data = 4'hA, count2 = 1.
  - Pulse out_ready[2] -> out_valid = 0, count2 = 0.
- Fill lane 1: push 1, 2, 3, 4 with out_ready = 0 -> count1 = 4, in_ready = 0 while in_sel = 1.
  - in_ready = 1 when in_sel = 0, and a beat to lane 0 is accepted meanwhile.
  - A 5th beat 4'h5 to lane 1 is held; draining lane 1 yields 1, 2, 3, 4, then 5 is accepted.
- Concurrent push/pop on lane 3 with count3 = 2 -> count3 stays 2 and the output order matches the input order.
  - Full-lane push plus pop in the same cycle -> push refused, count drops to DEPTH-1.
- Wrap/throughput: 10 consecutive beats 0..9 to lane 0 with out_ready[0] = 1 -> each beat appears one cycle after acceptance, in_ready stays high, pointers wrap twice, no loss.
- Reset mid-operation: lanes hold 2/3/1/4 beats when rst_n drops -> all counts 0 at once.
  - After release, beat 4'hC to lane 1 emerges as the sole lane-1 output.
